// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing the register-file/ALU datapath between the averaging
// controller (0) and the host/debug port (1), with bounded lock bursts and overflow routing.
module datapath_arbiter #(
  parameter int MAX_LOCK = 8
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             req0,
  input  logic                             lock0,
  input  logic [13:0]                      cmd0,
  output logic                             gnt0,
  output logic                             ovf0,
  input  logic                             req1,
  input  logic                             lock1,
  input  logic [13:0]                      cmd1,
  output logic                             gnt1,
  output logic                             ovf1,
  input  logic                             overflow,
  output logic [1:0]                       op,
  output logic [3:0]                       src1,
  output logic [3:0]                       src2,
  output logic [3:0]                       dest,
  output logic                             busy,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(MAX_LOCK+1)-1:0]    dbg_lock_cnt
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] lock_cnt;
  logic          last;
  logic          owner;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          acc_lock;
  logic [13:0]   acc_cmd;
  logic          last_burst;

  // Handshake: a requester holds req/lock/cmd stable until its gnt is high;
  // a command is accepted on a rising edge where req & gnt, one per cycle at most.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      LOCK0: grant0 = req0;
      LOCK1: grant1 = req1;
      default: begin
        if (req0 && req1) begin
          grant0 = last;
          grant1 = ~last;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
    endcase
  end

  // Grants are forced low while reset is held, even though state already reads ARB.
  assign gnt0 = grant0 & n_reset;
  assign gnt1 = grant1 & n_reset;

  assign accept     = grant0 | grant1;
  assign acc_lock   = grant0 ? lock0 : lock1;
  assign acc_cmd    = grant0 ? cmd0 : cmd1;
  assign last_burst = (int'(lock_cnt) + 1 >= MAX_LOCK);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ARB;
      lock_cnt <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      busy     <= 1'b0;
      op       <= 2'd0;
      src1     <= 4'hF;
      src2     <= 4'hF;
      dest     <= 4'hF;
    end else begin
      if (accept) begin
        {op, src1, src2, dest} <= acc_cmd;
        busy  <= 1'b1;
        owner <= grant1;
        last  <= grant1;
      end else begin
        op    <= 2'd0;
        src1  <= 4'hF;
        src2  <= 4'hF;
        dest  <= 4'hF;
        busy  <= 1'b0;
      end

      case (state)
        ARB: begin
          if (accept && acc_lock && MAX_LOCK > 1) begin
            state    <= grant0 ? LOCK0 : LOCK1;
            lock_cnt <= CW'(1);
          end
        end
        LOCK0, LOCK1: begin
          // Only the owner can be granted here, so !accept means the owner dropped req.
          if (!accept || !acc_lock || last_burst) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign ovf0 = overflow & busy & ~owner;
  assign ovf1 = overflow & busy & owner;

  assign dbg_state    = state;
  assign dbg_lock_cnt = lock_cnt;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Randomized bench for datapath_arbiter: a grant/ownership model feeds an expected-bus
// queue that a separate monitor drains and compares every cycle.
module tb_datapath_arbiter;

  localparam int MAX_LOCK = 8;
  localparam int CW       = $clog2(MAX_LOCK + 1);
  localparam int W        = 16;
  localparam logic [W-1:0] NOP_ENTRY = 16'h0FFF;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [13:0]   cmd0 = '0, cmd1 = '0;
  logic          overflow = 1'b0;
  logic          gnt0, gnt1, ovf0, ovf1, busy;
  logic [1:0]    op;
  logic [3:0]    src1, src2, dest;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_lock_cnt;

  datapath_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .n_reset(n_reset),
    .req0(req0), .lock0(lock0), .cmd0(cmd0), .gnt0(gnt0), .ovf0(ovf0),
    .req1(req1), .lock1(lock1), .cmd1(cmd1), .gnt1(gnt1), .ovf1(ovf1),
    .overflow(overflow), .op(op), .src1(src1), .src2(src2), .dest(dest), .busy(busy),
    .dbg_state(dbg_state), .dbg_lock_cnt(dbg_lock_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // entry = {busy, owner, cmd[13:0]}
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  // Reference model: who went last, who holds a lock, and how long the burst is.
  int m_last, m_lock_owner, m_burst;
  bit acc0 = 0, acc1 = 0, force0 = 0;
  bit e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_lock_owner = -1; m_burst = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
    check({tag, "_bus"}, 32'({busy, op, src1, src2, dest}), 32'h0FFF);
    check({tag, "_ovf"}, 32'({ovf0, ovf1}), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    n_reset = 1'b1;
    model_reset();
    acc0 = 0; acc1 = 0;
    exp_q.delete();
    exp_q.push_back(NOP_ENTRY);
    mon_en = 1'b1;
  endtask

  // One cycle: refresh requests at negedge, check grants, push the expected bus word.
  task automatic drive_cycle();
    int n;
    bit l;
    @(negedge clk);
    check("lock_cnt", 32'(dbg_lock_cnt), (m_lock_owner >= 0) ? 32'(m_burst) : 32'd0);
    check("state", 32'(dbg_state), (m_lock_owner < 0) ? 32'd0 : 32'(m_lock_owner + 1));
    if (acc0) begin req0 = 1'b0; acc0 = 0; end
    if (acc1) begin req1 = 1'b0; acc1 = 0; end
    if (!req0) begin
      if (force0 || $urandom_range(0, 3) != 0) begin
        req0  = 1'b1;
        lock0 = force0 ? 1'b1 : ($urandom_range(0, 4) != 0);
        if (!force0) cmd0 = 14'($urandom);
      end else lock0 = 1'($urandom_range(0, 1));
    end
    if (!req1) begin
      if ($urandom_range(0, 3) != 0) begin
        req1  = 1'b1;
        lock1 = ($urandom_range(0, 4) != 0);
        cmd1  = 14'($urandom);
      end else lock1 = 1'($urandom_range(0, 1));
    end
    overflow = 1'($urandom_range(0, 1));
    #1;
    if (m_lock_owner == 0) begin e0 = req0; e1 = 0; end
    else if (m_lock_owner == 1) begin e0 = 0; e1 = req1; end
    else if (req0 && req1) begin e0 = (m_last == 1); e1 = (m_last == 0); end
    else begin e0 = req0; e1 = req1; end
    check("gnt0", 32'(gnt0), 32'(e0));
    check("gnt1", 32'(gnt1), 32'(e1));
    if (e0)      exp_q.push_back({2'b10, cmd0});
    else if (e1) exp_q.push_back({2'b11, cmd1});
    else         exp_q.push_back(NOP_ENTRY);
    if (e0 || e1) begin
      n = e0 ? 0 : 1;
      l = e0 ? lock0 : lock1;
      m_last = n;
      if (m_lock_owner < 0) begin
        if (l && MAX_LOCK > 1) begin m_lock_owner = n; m_burst = 1; end
      end else begin
        m_burst++;
        if (!l || m_burst >= MAX_LOCK) begin m_lock_owner = -1; m_burst = 0; end
      end
      acc0 = e0; acc1 = e1;
    end else if (m_lock_owner >= 0) begin
      m_lock_owner = -1; m_burst = 0;
    end
  endtask

  // Monitor: the bus seen at each negedge belongs to the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] e;
      #2;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_queue: got empty queue expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("bus", 32'({busy, op, src1, src2, dest}), 32'({e[15], e[13:0]}));
        check("ovf0", 32'(ovf0), 32'(overflow & e[15] & ~e[14]));
        check("ovf1", 32'(ovf1), 32'(overflow & e[15] & e[14]));
      end
    end
  end

  initial begin
    int n0;
    bit seen1;
    bit hit;
    model_reset();

    // Both requesting and overflow high while reset is held.
    req0 = 1'b1; lock0 = 1'b1; cmd0 = 14'h3120;
    req1 = 1'b1; lock1 = 1'b0; cmd1 = 14'h1ABC;
    overflow = 1'b1;
    force0 = 1;
    #12;
    check_reset_outputs("reset");
    release_reset();

    // Requester 0 locks continuously while 1 waits: exactly MAX_LOCK grants, then 1.
    n0 = 0; seen1 = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle();
      if (!seen1 && gnt0) n0++;
      if (gnt1) seen1 = 1;
    end
    check("burst_len", 32'(n0), 32'(MAX_LOCK));
    check("burst_then_1", 32'(seen1), 32'd1);
    force0 = 0;

    for (int i = 0; i < 600; i++) drive_cycle();

    // Run until requester 1 holds a lock, then reset mid-burst.
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      drive_cycle();
      if (m_lock_owner == 1) hit = 1;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL lock1_wait: got no LOCK1 entry expected one within 3000 cycles");
    end
    #2;
    n_reset = 1'b0;
    mon_en  = 1'b0;
    acc0 = 0; acc1 = 0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_cnt", 32'(dbg_lock_cnt), 32'd0);
    if (!req0) begin req0 = 1'b1; lock0 = 1'b0; cmd0 = 14'($urandom); end
    if (!req1) begin req1 = 1'b1; lock1 = 1'b0; cmd1 = 14'($urandom); end
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    release_reset();
    drive_cycle();
    check("restart_pri", 32'(gnt0), 32'd1);

    for (int i = 0; i < 300; i++) drive_cycle();
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
